// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage pipelined YCbCr 4:4:4 -> RGB888 converter with aligned syncs
//   clk, rst (async, active high), ce (pipeline enable)
//   Y/Cb/Cr + in_hsync/in_vsync/in_de in; R/G/B + out_hsync/out_vsync/out_de out, 4 enabled cycles later
module ycbcr2rgb #(
  parameter int FULL_RANGE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de
);
  localparam logic signed [21:0] KY  = FULL_RANGE != 0 ? 22'sd1024 : 22'sd1192;
  localparam logic signed [21:0] KRV = FULL_RANGE != 0 ? 22'sd1436 : 22'sd1634;
  localparam logic signed [21:0] KGU = FULL_RANGE != 0 ? 22'sd352  : 22'sd401;
  localparam logic signed [21:0] KGV = FULL_RANGE != 0 ? 22'sd731  : 22'sd833;
  localparam logic signed [21:0] KBU = FULL_RANGE != 0 ? 22'sd1815 : 22'sd2065;
  localparam logic signed [9:0]  YOFF = FULL_RANGE != 0 ? 10'sd0 : 10'sd16;
  logic signed [9:0]  r_ys;
  logic signed [8:0]  r_cbs, r_crs;
  logic signed [21:0] r_py, r_prv, r_pgu, r_pgv, r_pbu;
  logic signed [11:0] r_r, r_g, r_b;
  logic [3:0][2:0]    r_sd;
  logic signed [21:0] w_r, w_g, w_b;
  // rounding constant 512 = half an LSB after the 10-bit shift
  assign w_r = r_py + r_prv + 22'sd512;
  assign w_g = r_py - r_pgu - r_pgv + 22'sd512;
  assign w_b = r_py + r_pbu + 22'sd512;
  function automatic logic [7:0] sat(input logic signed [11:0] v);
    return v[11] ? 8'd0 : (|v[10:8]) ? 8'hff : v[7:0];
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ys  <= '0;
      r_cbs <= '0;
      r_crs <= '0;
      r_py  <= '0;
      r_prv <= '0;
      r_pgu <= '0;
      r_pgv <= '0;
      r_pbu <= '0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
      R     <= '0;
      G     <= '0;
      B     <= '0;
      r_sd  <= '0;
    end else if (ce) begin
      r_ys  <= $signed({2'b00, Y}) - YOFF;
      r_cbs <= $signed({1'b0, Cb}) - 9'sd128;
      r_crs <= $signed({1'b0, Cr}) - 9'sd128;
      r_py  <= KY  * 22'(r_ys);
      r_prv <= KRV * 22'(r_crs);
      r_pgu <= KGU * 22'(r_cbs);
      r_pgv <= KGV * 22'(r_crs);
      r_pbu <= KBU * 22'(r_cbs);
      r_r   <= 12'(w_r >>> 10);
      r_g   <= 12'(w_g >>> 10);
      r_b   <= 12'(w_b >>> 10);
      R     <= sat(r_r);
      G     <= sat(r_g);
      B     <= sat(r_b);
      r_sd  <= {r_sd[2:0], {in_hsync, in_vsync, in_de}};
    end
  end
  assign {out_hsync, out_vsync, out_de} = r_sd[3];
endmodule
